// File: rtl/host_rx_timeout_sched.sv
// Ages host-RX buffer slots against the wrapping host RX timer and issues one expire request at a time.
// Optional expired-slot statistics counter is built when HRX_TIMEOUT_STAT_EN is defined.
module host_rx_timeout_sched #(
    parameter int SLOT_NUM  = 8,
    parameter int SLOT_W    = 3,
    parameter int TIMER_W   = 19,
    parameter int TIMER_MAX = 499999
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [TIMER_W-1:0] iv_timer,
    input  logic [TIMER_W-1:0] iv_timeout_thresh,
    input  logic               i_alloc_wr,
    input  logic [SLOT_W-1:0]  iv_alloc_slot,
    input  logic               i_free_wr,
    input  logic [SLOT_W-1:0]  iv_free_slot,
    output logic               o_expire_req,
    output logic [SLOT_W-1:0]  ov_expire_slot,
    input  logic               i_expire_ack,
    output logic               o_alloc_err,
    output logic [SLOT_W:0]    ov_active_cnt,
    output logic [15:0]        ov_expire_cnt
);

    typedef enum logic {SCAN, REQ} state_t;

    localparam logic [TIMER_W:0] WRAP = (TIMER_W+1)'(TIMER_MAX + 1);
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SLOT_NUM - 1);

    state_t                         state, state_nxt;
    logic [SLOT_NUM-1:0]            valid;
    logic [SLOT_NUM-1:0][TIMER_W-1:0] stamp;
    logic [SLOT_W-1:0]              ptr, ptr_nxt, slot_nxt;
    logic                           req_nxt;
    logic [TIMER_W-1:0]             cur_stamp;
    logic [TIMER_W:0]               elapsed;
    logic                           expired, collide, ack_fire;
    logic [SLOT_W:0]                cnt_nxt;

    // Modulo-(TIMER_MAX+1) age of the slot under the scan pointer.
    always_comb begin
        cur_stamp = stamp[ptr];
        if (iv_timer >= cur_stamp)
            elapsed = {1'b0, iv_timer} - {1'b0, cur_stamp};
        else
            elapsed = {1'b0, iv_timer} + WRAP - {1'b0, cur_stamp};
    end

    assign expired  = valid[ptr] && (|iv_timeout_thresh) && (elapsed >= {1'b0, iv_timeout_thresh});
    assign collide  = (i_free_wr && iv_free_slot == ptr) || (i_alloc_wr && iv_alloc_slot == ptr);
    assign ack_fire = (state == REQ) && i_expire_ack;

    // Slot table: alloc wins over the ack-clear, which wins over a normal free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid <= '0;
            stamp <= '0;
        end else begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                if (i_alloc_wr && iv_alloc_slot == SLOT_W'(i)) begin
                    valid[i] <= 1'b1;
                    stamp[i] <= iv_timer;
                end else if (ack_fire && ov_expire_slot == SLOT_W'(i)) begin
                    valid[i] <= 1'b0;
                end else if (i_free_wr && iv_free_slot == SLOT_W'(i)) begin
                    valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < SLOT_NUM; i++)
            cnt_nxt = cnt_nxt + (SLOT_W+1)'(valid[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_active_cnt <= '0;
            o_alloc_err   <= 1'b0;
        end else begin
            ov_active_cnt <= cnt_nxt;
            o_alloc_err   <= i_alloc_wr && valid[iv_alloc_slot];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= SCAN;
            ptr            <= '0;
            o_expire_req   <= 1'b0;
            ov_expire_slot <= '0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            o_expire_req   <= req_nxt;
            ov_expire_slot <= slot_nxt;
        end
    end

    // A slot touched by alloc/free in its scan cycle is skipped, not requested.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        req_nxt   = o_expire_req;
        slot_nxt  = ov_expire_slot;
        case (state)
            SCAN: begin
                if (expired && !collide) begin
                    slot_nxt  = ptr;
                    req_nxt   = 1'b1;
                    state_nxt = REQ;
                end else begin
                    ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
                end
            end
            REQ: begin
                if (i_expire_ack) begin
                    req_nxt   = 1'b0;
                    ptr_nxt   = (ov_expire_slot == LAST) ? '0 : ov_expire_slot + 1'b1;
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

`ifdef HRX_TIMEOUT_STAT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            ov_expire_cnt <= '0;
        else if (ack_fire && ov_expire_cnt != 16'hFFFF)
            ov_expire_cnt <= ov_expire_cnt + 16'd1;
    end
`else
    assign ov_expire_cnt = 16'd0;
`endif

endmodule
